// File: rtl/axi_lite_cfg_master.sv
// Single-outstanding AXI-Lite initiator: one command in, one AXI write or read out, one response back.
// Latency: zero-wait responder gives rsp_valid 3 cycles after the command handshake; next command at +4.
// Backpressure: cmd_ready low while busy; rsp held until rsp_ready; AXI stalls bounded by TIMEOUT_CYCLES.
//
// Ports:
//   reg_clk, reset_n       clock and synchronous active-low reset
//   cmd_*                  command request (valid/ready, write flag, address, write data, id)
//   rsp_*                  response (valid/ready, write echo, id echo, read data, response code)
//   aw*/w*/b*/ar*/r*       AXI-Lite master channels (rlast unused)
//   timeout_cnt/id_err_cnt saturating error counters
module axi_lite_cfg_master #(
    parameter int DATA_SIZE      = 32,
    parameter int ADDR_SIZE      = 32,
    parameter int ID_SIZE        = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   reg_clk,
    input  logic                   reset_n,
    // command port
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [ADDR_SIZE-1:0]   cmd_addr,
    input  logic [DATA_SIZE-1:0]   cmd_wdata,
    input  logic [ID_SIZE-1:0]     cmd_id,
    // response port
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_write,
    output logic [ID_SIZE-1:0]     rsp_id,
    output logic [DATA_SIZE-1:0]   rsp_rdata,
    output logic [1:0]             rsp_resp,
    // AXI write address / data / response
    output logic                   awvalid,
    input  logic                   awready,
    output logic [ADDR_SIZE-1:0]   awaddr,
    output logic [ID_SIZE-1:0]     awid,
    output logic                   wvalid,
    input  logic                   wready,
    output logic [DATA_SIZE-1:0]   wdata,
    output logic [DATA_SIZE/8-1:0] wstrb,
    input  logic                   bvalid,
    output logic                   bready,
    input  logic [ID_SIZE-1:0]     bid,
    input  logic [1:0]             bresp,
    // AXI read address / data
    output logic                   arvalid,
    input  logic                   arready,
    output logic [ADDR_SIZE-1:0]   araddr,
    output logic [ID_SIZE-1:0]     arid,
    input  logic                   rvalid,
    output logic                   rready,
    input  logic [DATA_SIZE-1:0]   rdata,
    input  logic [1:0]             rresp,
    input  logic [ID_SIZE-1:0]     rid,
    input  logic                   rlast,
    // error counters
    output logic [15:0]            timeout_cnt,
    output logic [15:0]            id_err_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_WR_AW_W, ST_WR_B, ST_RD_AR, ST_RD_R, ST_RSP
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t                 state_q;
    logic                   cmd_ready_q, awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic [ADDR_SIZE-1:0]   addr_q;
    logic [DATA_SIZE-1:0]   wdata_q;
    logic [ID_SIZE-1:0]     id_q;
    logic                   write_q;
    logic                   rsp_valid_q, rsp_write_q;
    logic [ID_SIZE-1:0]     rsp_id_q;
    logic [DATA_SIZE-1:0]   rsp_rdata_q;
    logic [1:0]             rsp_resp_q;
    logic [15:0]            tmo_q, timeout_cnt_q, id_err_cnt_q;

    logic                   busy, aw_w_done, term_hs, tmo_fire;
    logic [ID_SIZE-1:0]     ret_id;
    logic [1:0]             ret_resp, rsp_resp_d;
    logic                   id_mismatch;
    logic [DATA_SIZE-1:0]   rsp_rdata_d;
    logic [15:0]            timeout_cnt_d, id_err_cnt_d;
    logic                   unused_rlast;

    assign unused_rlast = rlast;

    always_comb begin
        busy      = (state_q == ST_WR_AW_W) || (state_q == ST_WR_B) ||
                    (state_q == ST_RD_AR)   || (state_q == ST_RD_R);
        // a dropped valid means that channel already handshook
        aw_w_done = (!awvalid_q || awready) && (!wvalid_q || wready);
        case (state_q)
            ST_WR_AW_W: term_hs = aw_w_done;
            ST_WR_B:    term_hs = bvalid;
            ST_RD_AR:   term_hs = arready;
            ST_RD_R:    term_hs = rvalid;
            default:    term_hs = 1'b0;
        endcase
        // >= keeps expiry armed if a phase finishes exactly on the last allowed cycle
        tmo_fire      = busy && (tmo_q >= TMO_LAST) && !term_hs;

        ret_id        = (state_q == ST_WR_B) ? bid : rid;
        ret_resp      = (state_q == ST_WR_B) ? bresp : rresp;
        id_mismatch   = (ret_id != id_q);
        rsp_resp_d    = id_mismatch ? 2'b10 : ret_resp;
        rsp_rdata_d   = (!write_q && rsp_resp_d == 2'b00) ? rdata : '0;
        timeout_cnt_d = (timeout_cnt_q == 16'hFFFF) ? timeout_cnt_q : timeout_cnt_q + 16'd1;
        id_err_cnt_d  = (id_err_cnt_q == 16'hFFFF) ? id_err_cnt_q : id_err_cnt_q + 16'd1;
    end

    always_ff @(posedge reg_clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            cmd_ready_q   <= 1'b0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            id_q          <= '0;
            write_q       <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_write_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= 2'b00;
            tmo_q         <= '0;
            timeout_cnt_q <= '0;
            id_err_cnt_q  <= '0;
        end else if (tmo_fire) begin
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_write_q   <= write_q;
            rsp_id_q      <= id_q;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= 2'b11;
            timeout_cnt_q <= timeout_cnt_d;
            state_q       <= ST_RSP;
        end else begin
            if (busy) begin
                tmo_q <= tmo_q + 16'd1;
            end
            case (state_q)
                ST_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        addr_q      <= cmd_addr;
                        wdata_q     <= cmd_wdata;
                        id_q        <= cmd_id;
                        write_q     <= cmd_write;
                        tmo_q       <= '0;
                        if (cmd_write) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= ST_WR_AW_W;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= ST_RD_AR;
                        end
                    end
                end
                ST_WR_AW_W: begin
                    if (aw_w_done) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b0;
                        bready_q  <= 1'b1;
                        state_q   <= ST_WR_B;
                    end else begin
                        if (awready) awvalid_q <= 1'b0;
                        if (wready)  wvalid_q  <= 1'b0;
                    end
                end
                ST_RD_AR: begin
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_RD_R;
                    end
                end
                ST_WR_B, ST_RD_R: begin
                    if (term_hs) begin
                        bready_q    <= 1'b0;
                        rready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_write_q <= write_q;
                        rsp_id_q    <= id_q;
                        rsp_rdata_q <= rsp_rdata_d;
                        rsp_resp_q  <= rsp_resp_d;
                        if (id_mismatch) id_err_cnt_q <= id_err_cnt_d;
                        state_q     <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_write   = rsp_write_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_resp    = rsp_resp_q;
    assign awvalid     = awvalid_q;
    assign awaddr      = addr_q;
    assign awid        = id_q;
    assign wvalid      = wvalid_q;
    assign wdata       = wdata_q;
    assign wstrb       = '1;
    assign bready      = bready_q;
    assign arvalid     = arvalid_q;
    assign araddr      = addr_q;
    assign arid        = id_q;
    assign rready      = rready_q;
    assign timeout_cnt = timeout_cnt_q;
    assign id_err_cnt  = id_err_cnt_q;

endmodule

// File: tb/tb_axi_lite_cfg_master.sv
// Bench for axi_lite_cfg_master: randomized commands against a behavioural responder and response model.
// Latency: expected response cycle derived from responder delays and the timeout window.
// Backpressure: random rsp_ready delay; responder stalls AW/W/AR/B/R by configurable cycles.
module tb_axi_lite_cfg_master;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int IW  = 32;
    localparam int TMO = 8;

    logic          clk;
    logic          reset_n;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [IW-1:0] cmd_id;
    logic          rsp_valid, rsp_ready, rsp_write;
    logic [IW-1:0] rsp_id;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready, rlast;
    logic [AW-1:0] awaddr, araddr;
    logic [IW-1:0] awid, arid, bid, rid;
    logic [DW-1:0] wdata, rdata;
    logic [3:0]    wstrb;
    logic [1:0]    bresp, rresp;
    logic [15:0]   timeout_cnt, id_err_cnt;

    axi_lite_cfg_master #(
        .DATA_SIZE(DW), .ADDR_SIZE(AW), .ID_SIZE(IW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .reg_clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_id(cmd_id),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .rid(rid), .rlast(rlast),
        .timeout_cnt(timeout_cnt), .id_err_cnt(id_err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // responder knobs
    int          k_aw_dly, k_w_dly, k_b_dly, k_ar_dly, k_r_dly, k_hang;
    bit          k_bad_id, k_early;
    logic [1:0]  k_resp;
    logic [31:0] k_rdata;
    // what the responder saw at address/data handshakes
    logic [31:0] got_awaddr, got_awid, got_wdata, got_araddr, got_arid;
    logic [3:0]  got_wstrb;

    task automatic set_knobs(input int aw, input int w, input int b, input int ar, input int r,
                             input int hang, input bit bad, input bit early,
                             input logic [1:0] resp, input logic [31:0] rd);
        k_aw_dly = aw; k_w_dly = w; k_b_dly = b; k_ar_dly = ar; k_r_dly = r;
        k_hang = hang; k_bad_id = bad; k_early = early; k_resp = resp; k_rdata = rd;
    endtask

    // AXI-Lite responder: decides ready/valid at each falling edge from the DUT's registered outputs
    initial begin
        int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        awready = 0; wready = 0; bvalid = 0; bid = '0; bresp = '0;
        arready = 0; rvalid = 0; rdata = '0; rresp = '0; rid = '0; rlast = 0;
        forever begin
            @(negedge clk);
            if (awvalid) begin
                awready = (k_hang != 1) && (aw_cnt >= k_aw_dly);
                if (awready) begin got_awaddr = awaddr; got_awid = awid; end
                aw_cnt++;
            end else begin awready = 0; aw_cnt = 0; end
            if (wvalid) begin
                wready = (w_cnt >= k_w_dly);
                if (wready) begin got_wdata = wdata; got_wstrb = wstrb; end
                w_cnt++;
            end else begin wready = 0; w_cnt = 0; end
            if (bready) begin
                bvalid = (k_hang != 2) && (b_cnt >= k_b_dly);
                bresp  = k_resp;
                bid    = k_bad_id ? ~got_awid : got_awid;
                b_cnt++;
            end else if (k_early && (awvalid || wvalid)) begin
                bvalid = 1; bresp = 2'b11; bid = ~awid; b_cnt = 0;
            end else begin bvalid = 0; b_cnt = 0; end
            if (arvalid) begin
                arready = (k_hang != 1) && (ar_cnt >= k_ar_dly);
                if (arready) begin got_araddr = araddr; got_arid = arid; end
                ar_cnt++;
            end else begin arready = 0; ar_cnt = 0; end
            if (rready) begin
                rvalid = (k_hang != 2) && (r_cnt >= k_r_dly);
                rresp  = k_resp;
                rdata  = k_rdata;
                rid    = k_bad_id ? ~got_arid : got_arid;
                r_cnt++;
            end else if (k_early && arvalid) begin
                rvalid = 1; rresp = 2'b00; rdata = 32'hBAD0_BAD0; rid = arid; r_cnt = 0;
            end else begin rvalid = 0; r_cnt = 0; end
        end
    end

    // observations from the last transaction
    bit          t_ok;
    logic        s1_aw, s1_w, s1_ar, s2_aw, s2_w, s2_ar, s2_b, s2_r;
    int          r_off;
    logic        r_write, r_axi_busy, r_cmd_busy, r_cmd_next, r_rsp_after;
    logic [31:0] r_id, r_rdata;
    logic [1:0]  r_resp;
    int          exp_tmo = 0;
    int          exp_iderr = 0;

    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] id, input int rdly);
        int n;
        int c0;
        t_ok = 0;
        got_awaddr = 'x; got_awid = 'x; got_wdata = 'x; got_wstrb = 'x; got_araddr = 'x; got_arid = 'x;
        cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_id = id; cmd_valid = 1;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        if (!cmd_ready) begin
            check_eq("cmd_accept", 0, 1);
            cmd_valid = 0;
            return;
        end
        c0 = cyc;
        @(negedge clk);
        cmd_valid = 0; cmd_addr = ~addr; cmd_wdata = ~data; cmd_id = ~id; cmd_write = ~wr;
        s1_aw = awvalid; s1_w = wvalid; s1_ar = arvalid;
        @(negedge clk);
        s2_aw = awvalid; s2_w = wvalid; s2_ar = arvalid; s2_b = bready; s2_r = rready;
        n = 0;
        while (!rsp_valid && n < 60) begin @(negedge clk); n++; end
        if (!rsp_valid) begin
            check_eq("rsp_seen", 0, 1);
            return;
        end
        r_off = cyc - c0;
        repeat (rdly) @(negedge clk);
        r_write = rsp_write; r_id = rsp_id; r_rdata = rsp_rdata; r_resp = rsp_resp;
        r_axi_busy = awvalid | wvalid | bready | arvalid | rready;
        r_cmd_busy = cmd_ready;
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        r_cmd_next = cmd_ready; r_rsp_after = rsp_valid;
        t_ok = 1;
    endtask

    // reference: response code, data, timing and counters from the responder's behaviour
    task automatic check_txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                             input logic [31:0] id, input int rdly);
        int hs, exp_off;
        bit to;
        logic [1:0]  er;
        logic [31:0] ed;
        if (!t_ok) return;
        if (k_hang != 0)  hs = 1000;
        else if (wr)      hs = ((k_aw_dly > k_w_dly) ? k_aw_dly : k_w_dly) + k_b_dly + 2;
        else              hs = k_ar_dly + k_r_dly + 2;
        to = (hs > TMO);
        if (to) begin
            er = 2'b11; exp_off = TMO + 1;
            if (exp_tmo < 65535) exp_tmo++;
        end else begin
            er = k_bad_id ? 2'b10 : k_resp; exp_off = hs + 1;
            if (k_bad_id && exp_iderr < 65535) exp_iderr++;
        end
        ed = (!wr && er == 2'b00) ? k_rdata : 32'h0;
        check_eq("rsp_cycle", r_off, exp_off + rdly - rdly);
        check_eq("rsp_resp", r_resp, er);
        check_eq("rsp_rdata", r_rdata, ed);
        check_eq("rsp_id", r_id, id);
        check_eq("rsp_write", r_write, wr);
        check_eq("axi_idle_in_rsp", r_axi_busy, 0);
        check_eq("cmd_ready_busy", r_cmd_busy, 0);
        check_eq("cmd_ready_after", r_cmd_next, 1);
        check_eq("rsp_valid_after", r_rsp_after, 0);
        check_eq("timeout_cnt", timeout_cnt, exp_tmo);
        check_eq("id_err_cnt", id_err_cnt, exp_iderr);
        if (wr) begin
            check_eq("wdata", got_wdata, data);
            check_eq("wstrb", got_wstrb, 4'hF);
            if (k_hang != 1) begin
                check_eq("awaddr", got_awaddr, addr);
                check_eq("awid", got_awid, id);
            end
        end else if (k_hang != 1) begin
            check_eq("araddr", got_araddr, addr);
            check_eq("arid", got_arid, id);
        end
    endtask

    task automatic txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [31:0] id, input int rdly);
        run_txn(wr, addr, data, id, rdly);
        check_txn(wr, addr, data, id, rdly);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_cmd_ready"}, cmd_ready, 0);
        check_eq({pfx, "_valids"}, {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 0);
        check_eq({pfx, "_addr_data_id"}, {awaddr, araddr, wdata, awid, arid}, 0);
        check_eq({pfx, "_rsp_fields"}, {rsp_write, rsp_id, rsp_rdata, rsp_resp}, 0);
        check_eq({pfx, "_wstrb"}, wstrb, 4'hF);
        check_eq({pfx, "_counters"}, {timeout_cnt, id_err_cnt}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_id = '0;
        rsp_ready = 0;
        set_knobs(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1;
        @(negedge clk);
        check_eq("cmd_ready_after_reset", cmd_ready, 1);

        // zero-wait write: AW/W at cycle 1, B at cycle 2, rsp at 3, next cmd at 4
        txn(1, 32'h4005, 32'h7, 32'd3, 0);
        check_eq("wr0_c1_aw_w", {s1_aw, s1_w}, 2'b11);
        check_eq("wr0_c2_bready", {s2_aw, s2_w, s2_b}, 3'b001);

        // read with 5-cycle AR stall
        set_knobs(0, 0, 0, 5, 0, 0, 0, 0, 2'b00, 32'hDEAD_BEEF);
        txn(0, 32'h3002, 32'h0, 32'd9, 0);
        check_eq("rd_ar_held", s2_ar, 1);

        // zero-wait read timing
        set_knobs(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 32'h1234_5678);
        txn(0, 32'h0010, 32'h0, 32'd4, 0);
        check_eq("rd0_c1_ar", s1_ar, 1);
        check_eq("rd0_c2_rready", {s2_ar, s2_r}, 2'b01);

        // AW late, W immediate, early bvalid must be ignored
        set_knobs(3, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0);
        txn(1, 32'h0100, 32'hCAFE_0001, 32'd5, 1);
        check_eq("split_c2_aw_w_b", {s2_aw, s2_w, s2_b}, 3'b100);

        // early rvalid before AR completes must be ignored
        set_knobs(0, 0, 0, 2, 1, 0, 0, 1, 2'b00, 32'h0BAD_CAFE);
        txn(0, 32'h0104, 32'h0, 32'd6, 0);

        // SLVERR write then ID-mismatch read
        set_knobs(0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 0);
        txn(1, 32'h0200, 32'h55, 32'd7, 0);
        set_knobs(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 32'hFFFF_0000);
        txn(0, 32'h0204, 32'h0, 32'd8, 0);

        // AR never accepted: timeout, then normal command
        set_knobs(0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0);
        txn(0, 32'h0300, 32'h0, 32'd10, 0);
        set_knobs(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        txn(1, 32'h0304, 32'hA5A5_A5A5, 32'd11, 0);

        // handshake on the expiry cycle completes; one cycle later times out
        set_knobs(0, 0, 0, 3, 3, 0, 0, 0, 2'b00, 32'h600D_0001);
        txn(0, 32'h0400, 32'h0, 32'd12, 0);
        set_knobs(0, 0, 0, 3, 4, 0, 0, 0, 2'b00, 32'h600D_0002);
        txn(0, 32'h0404, 32'h0, 32'd13, 0);

        // reset while waiting for B with rsp_ready low
        set_knobs(0, 0, 0, 0, 0, 2, 0, 0, 2'b00, 0);
        cmd_write = 1; cmd_addr = 32'h0500; cmd_wdata = 32'h99; cmd_id = 32'd14; cmd_valid = 1;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        cmd_valid = 0;
        n = 0;
        while (!bready && n < 20) begin @(negedge clk); n++; end
        check_eq("rst_reached_wr_b", bready, 1);
        reset_n = 0;
        @(negedge clk);
        check_reset_outputs("midrst");
        reset_n = 1;
        exp_tmo = 0; exp_iderr = 0;
        set_knobs(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        @(negedge clk);
        check_eq("midrst_cmd_ready", cmd_ready, 1);
        check_eq("midrst_no_rsp", rsp_valid, 0);
        txn(1, 32'h0504, 32'h1, 32'd15, 0);

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            bit          wr;
            int          hang;
            logic [31:0] a, d, id;
            wr   = 1'($urandom_range(0, 1));
            hang = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
            set_knobs(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                      int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), hang,
                      ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
                      2'($urandom_range(0, 3)), $urandom);
            a = $urandom; d = $urandom; id = $urandom;
            txn(wr, a, d, id, int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_lite_cfg_master.md
# axi_lite_cfg_master

- Single-outstanding AXI-Lite initiator that turns simple command-port requests into AXI-Lite write and read transactions.
- Used to program and read back the register memory (output-port table, CRC table, connection-config table) from a sequencer or CPU-bridge side.
- Drives the `axi_lite_inf` master side and returns one response per command.
- Adds a per-transaction timeout, an ID-mismatch check and error counters so a hung or misbehaving responder cannot lock up configuration.

## Interface
Parameters:
- DATA_SIZE, 32, AXI-Lite data width
- ADDR_SIZE, 32, AXI-Lite address width
- ID_SIZE, 32, AXI ID width
- TIMEOUT_CYCLES, 1024, cycles allowed from address issue to B/R handshake; legal range 2..65535

Ports:
- One clock; reset is synchronous and active-low.
- reg_clk  in  1  clock; all logic on posedge
- reset_n  in  1  synchronous active-low reset
- cmd_valid / cmd_ready  in/out  1  command handshake
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_SIZE  target byte address, passed through unchanged
- cmd_wdata  in  DATA_SIZE  write data (ignored for reads)
- cmd_id  in  ID_SIZE  transaction ID
- rsp_valid / rsp_ready  out/in  1  response handshake
- rsp_write  out  1  echo of cmd_write
- rsp_id  out  ID_SIZE  echo of cmd_id
- rsp_rdata  out  DATA_SIZE  read data; 0 for writes and errors
- rsp_resp  out  2  00 OKAY, 10 SLVERR or ID mismatch, 11 timeout
- awvalid/awready, awaddr, awid  AXI write-address channel (master side)
- wvalid/wready, wdata, wstrb  AXI write-data channel; wstrb is all ones
- bvalid/bready, bid, bresp  AXI write-response channel
- arvalid/arready, araddr, arid  AXI read-address channel
- rvalid/rready, rdata, rresp, rid, rlast  AXI read-data channel; rlast is ignored
- timeout_cnt  out  16  saturating count of timed-out transactions
- id_err_cnt  out  16  saturating count of bid/rid mismatches

## Operation
States are IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP.

- IDLE:
  - cmd_ready = 1.
  - On a command handshake, latch addr, wdata, id and write into registers.
  - Go to WR_AW_W or RD_AR.
- WR_AW_W:
  - awvalid and wvalid are asserted independently.
  - Each valid drops on its own handshake.
  - AW and W may complete in either order or in the same cycle.
  - Go to WR_B once both have completed.
- WR_B:
  - bready = 1.
  - On bvalid, capture bresp and bid, then go to RSP.
- RD_AR:
  - arvalid is held until arready, then go to RD_R.
- RD_R:
  - rready = 1.
  - On rvalid, capture rdata, rresp and rid, then go to RSP.
- RSP:
  - rsp_valid = 1 and its fields are held stable until rsp_ready.
  - Go to IDLE on the handshake.
- Response code:
  - If the returned ID differs from the latched ID, rsp_resp = 10 and id_err_cnt increments.
  - Otherwise rsp_resp = the captured bresp/rresp; the 01 and 11 codes from the responder pass through.
  - rsp_rdata = rdata only for an OKAY read; otherwise 0.
- Timeout:
  - The counter loads 0 when entering WR_AW_W or RD_AR and increments each cycle in WR_AW_W, WR_B, RD_AR and RD_R.
  - When it reaches TIMEOUT_CYCLES-1 with no terminating handshake that cycle, drop all AXI valid/ready signals next cycle and go to RSP.
  - The response is rsp_resp = 11 and rsp_rdata = 0; timeout_cnt increments.
  - A handshake that occurs in the same cycle as expiry wins: it is a normal completion.
- Counters saturate at 0xFFFF and reset to 0 only on reset.
- Address, data and ID outputs are driven from the latched registers only, never combinationally from cmd_*.

## Timing
- Reset values: all valid/ready outputs 0 (including cmd_ready), awaddr/araddr/wdata/awid/arid/rsp_* 0, wstrb all ones, counters 0, state IDLE.
- In the first cycle after reset release, cmd_ready = 1.
- Reset asserted mid-transaction:
  - Abandon the transaction; no response is issued.
  - All outputs take their reset values on the next edge.
- Write latency with zero-wait responder:
  - Command handshake at cycle 0.
  - awvalid and wvalid high at cycle 1, handshaking at cycle 1.
  - bready high at cycle 2; bvalid handshake at cycle 2.
  - rsp_valid at cycle 3.
- Read latency with zero-wait responder: arvalid at cycle 1, rready at cycle 2, rsp_valid at cycle 3.
- Throughput: cmd_ready is low from the handshake cycle +1 until the cycle after the rsp handshake. With rsp_ready tied high, the next command is accepted at cycle 4.
- AXI rule: once asserted, a valid stays high with stable payload until its handshake. The only exception is timeout expiry.
- bvalid or rvalid arriving early (before AW/AR completes) is ignored; it is not captured.

## Test plan
- Write 0x0000_0007 to 0x4005 with ID 3, zero-wait responder:
  - AW and W handshake at cycle 1.
  - rsp_valid at cycle 3 with rsp_resp=00, rsp_id=3, rsp_write=1, rsp_rdata=0.
- Read 0x3002 where the responder returns rdata=0xDEAD_BEEF, rresp=00 after 5 wait cycles:
  - arvalid is held until arready.
  - The response carries rsp_rdata=0xDEAD_BEEF and rsp_resp=00.
- Write with AW ready at cycle 4 and W ready at cycle 1:
  - wvalid drops after cycle 1 while awvalid stays high.
  - B is accepted only after both complete.
- Responder returns bresp=10, then rid≠arid on a later read:
  - The write response has rsp_resp=10.
  - The read response has rsp_resp=10, rsp_rdata=0 and id_err_cnt=1.
- TIMEOUT_CYCLES=8, responder never asserts arready:
  - arvalid drops after 8 cycles.
  - The response has rsp_resp=11 and timeout_cnt=1.
  - The next command is accepted normally.
- Reset in WR_B with rsp_ready=0:
  - No rsp_valid is issued; all outputs are at reset values after one edge.
  - cmd_ready=1 after reset release.
